beat_judge: RTL and testbench
=============================

# beat_judge

Rhythm-game hit judge that produces the `niceplay` event stream consumed by the combo/score tracker. It plays an 8-slot note pattern on a fixed beat grid and compares rising edges of the player button against a timing window around each note. Each judgement produces one single-cycle pulse:
- `niceplay` for a good hit.
- `miss` for a missed or wrong press.

The block sits between the debounced button input and the score logic.

## Interface
Parameters:
- `BEAT_PERIOD`, 16: clock cycles per beat slot. Must be even and ≥ 2*`WINDOW`+4.
- `WINDOW`, 2: half-width of the hit window, in cycles.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run; sampled only in IDLE.
- `pattern`  in  8  note map, bit i = note in slot i; latched at start.
- `button`  in  1  player button level, already synchronous and debounced.
- `niceplay`  out  1  1-cycle pulse: good hit.
- `miss`  out  1  1-cycle pulse: missed note or wrong press.
- `beat`  out  1  1-cycle strobe at each slot centre while running.
- `beat_idx`  out  3  current slot index.
- `running`  out  1  high during a run.
- `done`  out  1  1-cycle pulse when a run completes.

## Operation
- Derived constant: CENTER = `BEAT_PERIOD`/2.
  - Window = phases CENTER-`WINDOW` .. CENTER+`WINDOW` inclusive.
  - Window-close phase = CENTER+`WINDOW`+1.
- Internal state:
  - `phase` counter, width clog2(`BEAT_PERIOD`).
  - `idx` counter, 3 bits.
  - Latched pattern register, 8 bits.
  - `judged` flag.
  - `button_d`, the button delayed one cycle.
- `press` = `button` & ~`button_d`. Only rising edges count; a held button never re-triggers.
- FSM states are IDLE and RUN.
  - IDLE, `start`=1: latch `pattern`, clear `phase`, `idx` and `judged`, go to RUN.
  - RUN, `phase` = `BEAT_PERIOD`-1 and `idx` < 7: clear `phase`, increment `idx`, clear `judged`.
  - RUN, `phase` = `BEAT_PERIOD`-1 and `idx` = 7: go to IDLE and pulse `done`.
  - Otherwise in RUN: increment `phase`.
  - `start` is ignored while in RUN.
- Judgement rules in RUN, where the slot has a note if pattern[idx]=1:
  - Note slot, `press` inside the window, `judged`=0: `niceplay` pulse and set `judged`.
  - Note slot, `press` outside the window, `judged`=0: `miss` pulse. `judged` is not set, so a later in-window press can still hit.
  - Note slot, `phase` = window-close, `judged`=0: `miss` pulse and set `judged`. A press in the same cycle does not add a second pulse.
  - Note slot, `press` while `judged`=1: ignored.
  - Empty slot, any `press`: `miss` pulse.
- Presses in IDLE are ignored.
- `niceplay` and `miss` are never high in the same cycle.
- `beat` = `running` & (`phase` = CENTER).
- `beat_idx` = `idx`.

## Timing
- Reset values:
  - All outputs = 0.
  - `phase`, `idx`, `judged`, `button_d` and the pattern register = 0.
  - FSM = IDLE.
- `rst` mid-run: the next edge forces IDLE and all reset values. A pending pulse is dropped. A new `start` is required.
- `start` sampled high at edge t: `running`=1, `phase`=0 and `idx`=0 from t onward.
- A run lasts exactly 8*`BEAT_PERIOD` cycles. At the final edge:
  - `running` falls.
  - `done`=1 for that one cycle.
- `niceplay` and `miss` are registered. Each is high for the one cycle following the edge at which the triggering `press` or window-close condition was sampled.
- `beat` is combinational from registered state, so it is glitch-free.
- No outputs are driven combinationally from inputs.

## Test plan
All scenarios use defaults: CENTER=8, window = phases 6..10, window-close = phase 11.
- Reset: hold `rst` 3 cycles with `button` toggling -> all outputs 0, `beat_idx`=0.
- Hit: `pattern`=0x01, `start`, button rises at slot 0 phase 8 -> exactly one `niceplay` pulse, 0 `miss`. After 128 cycles, `done` pulses once and `running`=0.
- Missed note: `pattern`=0x01, no press -> exactly one `miss`, in the cycle after slot 0 phase 11; no `niceplay`.
- Early then good: `pattern`=0x01, presses at phase 4 and at phase 7 -> `miss` after the first press, `niceplay` after the second; no window-close miss.
- Full pattern: `pattern`=0xFF, a press at phase 8 of every slot -> 8 `niceplay` pulses, 0 `miss`, 8 `beat` strobes. Also, a press on an empty slot with `pattern`=0xFE at slot 0 -> `miss`.
- Held button and reset: `button` held high from slot 1 to slot 3 -> at most one judgement from the single edge. Then `rst` at slot 3 phase 5 -> `running`=0 next cycle, and a following `start` restarts at `idx`=0.

Source files
------------

// File: rtl/beat_judge_if.sv
// Signal bundle between the button/score side and the beat_judge hit judge.
// clk and rst stay as plain ports on the modules.
interface beat_judge_if;
    logic       start;
    logic [7:0] pattern;
    logic       button;
    logic       niceplay;
    logic       miss;
    logic       beat;
    logic [2:0] beat_idx;
    logic       running;
    logic       done;

    modport master (
        output start, pattern, button,
        input  niceplay, miss, beat, beat_idx, running, done
    );

    modport slave (
        input  start, pattern, button,
        output niceplay, miss, beat, beat_idx, running, done
    );
endinterface

// File: rtl/beat_judge.sv
// Rhythm hit judge: plays an 8-slot note pattern, one registered niceplay/miss pulse per judgement.
// Pulses appear one cycle after the sampled press or window close; no backpressure, the score side must accept every pulse.
module beat_judge #(
    parameter int BEAT_PERIOD = 16,
    parameter int WINDOW      = 2
) (
    input  logic         clk,
    input  logic         rst,
    beat_judge_if.slave  bif
);
    localparam int PW     = $clog2(BEAT_PERIOD);
    localparam int CENTER = BEAT_PERIOD / 2;

    localparam logic [PW-1:0] PH_CENTER = PW'(CENTER);
    localparam logic [PW-1:0] PH_WIN_LO = PW'(CENTER - WINDOW);
    localparam logic [PW-1:0] PH_WIN_HI = PW'(CENTER + WINDOW);
    localparam logic [PW-1:0] PH_CLOSE  = PW'(CENTER + WINDOW + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(BEAT_PERIOD - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q,    state_d;
    logic [PW-1:0] phase_q,    phase_d;
    logic [2:0]    idx_q,      idx_d;
    logic [7:0]    pat_q,      pat_d;
    logic          judged_q,   judged_d;
    logic          button_d_q, button_d_d;
    logic          niceplay_q, niceplay_d;
    logic          miss_q,     miss_d;
    logic          done_q,     done_d;

    logic press;
    logic in_win;
    logic note;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        pat_d      = pat_q;
        judged_d   = judged_q;
        button_d_d = bif.button;
        niceplay_d = 1'b0;
        miss_d     = 1'b0;
        done_d     = 1'b0;

        press  = bif.button & ~button_d_q;
        in_win = (phase_q >= PH_WIN_LO) && (phase_q <= PH_WIN_HI);
        note   = pat_q[idx_q];

        if (state_q == IDLE) begin
            if (bif.start) begin
                state_d  = RUN;
                pat_d    = bif.pattern;
                phase_d  = '0;
                idx_d    = '0;
                judged_d = 1'b0;
            end
        end else begin
            // An out-of-window press leaves the note open; only a hit or the close judges it.
            if (note) begin
                if (!judged_q) begin
                    if (press && in_win) begin
                        niceplay_d = 1'b1;
                        judged_d   = 1'b1;
                    end else if (phase_q == PH_CLOSE) begin
                        miss_d   = 1'b1;
                        judged_d = 1'b1;
                    end else if (press) begin
                        miss_d = 1'b1;
                    end
                end
            end else if (press) begin
                miss_d = 1'b1;
            end

            if (phase_q == PH_LAST) begin
                if (idx_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d  = '0;
                    idx_d    = idx_q + 3'd1;
                    judged_d = 1'b0;
                end
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            idx_q      <= '0;
            pat_q      <= '0;
            judged_q   <= 1'b0;
            button_d_q <= 1'b0;
            niceplay_q <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            pat_q      <= pat_d;
            judged_q   <= judged_d;
            button_d_q <= button_d_d;
            niceplay_q <= niceplay_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
        end
    end

    assign bif.niceplay = niceplay_q;
    assign bif.miss     = miss_q;
    assign bif.done     = done_q;
    assign bif.running  = (state_q == RUN);
    assign bif.beat     = (state_q == RUN) && (phase_q == PH_CENTER);
    assign bif.beat_idx = idx_q;
endmodule

// File: tb/tb_beat_judge.sv
// Bench for beat_judge: vector table of whole runs, hand sequences, and random runs against a cycle-count model.
module tb_beat_judge;
    localparam int BP = 16;
    localparam int W  = 2;
    localparam int C  = BP / 2;
    localparam int RUN_LEN = 8 * BP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beat_judge_if bif();

    beat_judge #(.BEAT_PERIOD(BP), .WINDOW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    int total = 0;
    int bad   = 0;
    int nice_cnt, miss_cnt, done_cnt, beat_cnt;

    // Reference model: run position kept as cycles elapsed since start.
    bit         m_run;
    int         m_k;
    logic [7:0] m_pat;
    bit         m_hit [8];
    bit         m_prev;
    bit         e_nice, e_miss, e_done;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] smask;
        int         ph_a;
        int         ph_b;
        int         exp_nice;
        int         exp_miss;
    } row_t;

    row_t rows [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input logic [7:0] p, input bit b);
        bit press;
        int slot, ph;
        press  = b && !m_prev;
        m_prev = b;
        e_nice = 1'b0;
        e_miss = 1'b0;
        e_done = 1'b0;
        if (r) begin
            m_run = 1'b0; m_k = 0; m_pat = '0; m_prev = 1'b0;
            foreach (m_hit[i]) m_hit[i] = 1'b0;
        end else if (!m_run) begin
            if (s) begin
                m_run = 1'b1; m_k = 0; m_pat = p;
                foreach (m_hit[i]) m_hit[i] = 1'b0;
            end
        end else begin
            slot = m_k / BP;
            ph   = m_k % BP;
            if (m_pat[slot]) begin
                if (!m_hit[slot]) begin
                    if (press && ph >= C - W && ph <= C + W) begin
                        e_nice = 1'b1; m_hit[slot] = 1'b1;
                    end else if (ph == C + W + 1) begin
                        e_miss = 1'b1; m_hit[slot] = 1'b1;
                    end else if (press) begin
                        e_miss = 1'b1;
                    end
                end
            end else if (press) begin
                e_miss = 1'b1;
            end
            m_k++;
            if (m_k == RUN_LEN) begin
                m_run  = 1'b0;
                e_done = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [7:0] p, input bit b);
        logic [7:0] got, exp;
        logic [2:0] e_idx;
        bit         e_beat;
        rst         = r;
        bif.start   = s;
        bif.pattern = p;
        bif.button  = b;
        @(posedge clk);
        model_edge(r, s, p, b);
        #1;
        e_beat = m_run && ((m_k % BP) == C);
        e_idx  = (m_k / BP > 7) ? 3'd7 : 3'(m_k / BP);
        got = {bif.niceplay, bif.miss, bif.beat, bif.beat_idx, bif.running, bif.done};
        exp = {e_nice, e_miss, e_beat, e_idx, m_run, e_done};
        check("cycle_outputs", 32'(got), 32'(exp));
        nice_cnt += int'(bif.niceplay);
        miss_cnt += int'(bif.miss);
        done_cnt += int'(bif.done);
        beat_cnt += int'(bif.beat);
    endtask

    task automatic clear_counts();
        nice_cnt = 0; miss_cnt = 0; done_cnt = 0; beat_cnt = 0;
    endtask

    task automatic run_row(input row_t rw, input int n);
        bit b;
        step(1'b0, 1'b1, rw.pat, 1'b0);
        clear_counts();
        for (int k = 0; k < RUN_LEN; k++) begin
            b = rw.smask[k / BP] && ((k % BP) == rw.ph_a || (k % BP) == rw.ph_b);
            step(1'b0, 1'b0, rw.pat, b);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check($sformatf("row%0d_niceplay_count", n), 32'(nice_cnt), 32'(rw.exp_nice));
        check($sformatf("row%0d_miss_count", n), 32'(miss_cnt), 32'(rw.exp_miss));
        check($sformatf("row%0d_done_count", n), 32'(done_cnt), 32'd1);
        check($sformatf("row%0d_beat_count", n), 32'(beat_cnt), 32'd8);
        check($sformatf("row%0d_running_after", n), 32'(bif.running), 32'd0);
    endtask

    initial begin
        bit b;
        bit s;
        rst = 1'b1; bif.start = 1'b0; bif.pattern = '0; bif.button = 1'b0;
        m_run = 1'b0; m_k = 0; m_pat = '0; m_prev = 1'b0;
        foreach (m_hit[i]) m_hit[i] = 1'b0;
        clear_counts();

        //          pat    slots  ph_a ph_b nice miss
        rows[0] = '{8'h01, 8'h01,  8,  -1,  1,   0};  // clean hit at centre
        rows[1] = '{8'h01, 8'h00, -1,  -1,  0,   1};  // no press -> close miss
        rows[2] = '{8'h01, 8'h01,  4,   7,  1,   1};  // early then good
        rows[3] = '{8'hFF, 8'hFF,  8,  -1,  8,   0};  // full pattern
        rows[4] = '{8'hFE, 8'h01,  8,  -1,  0,   8};  // empty slot press + 7 close misses
        rows[5] = '{8'h01, 8'h01, 11,  -1,  0,   1};  // press on close phase: single pulse
        rows[6] = '{8'h01, 8'h01,  6,  10,  1,   0};  // lower edge hits, later press ignored
        rows[7] = '{8'h01, 8'h01,  5,  10,  1,   1};  // just early, then upper edge hits
        rows[8] = '{8'hAA, 8'hFF,  8,  -1,  4,   4};  // alternating notes
        rows[9] = '{8'h01, 8'h01, 12,  -1,  0,   1};  // late press after close ignored

        // Reset with button toggling
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hFF, i[0]);
            check("reset_outputs",
                  32'({bif.niceplay, bif.miss, bif.beat, bif.beat_idx, bif.running, bif.done}), 32'd0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);

        foreach (rows[i]) run_row(rows[i], i);

        // Held button from slot 1 through slot 3, then reset at slot 3 phase 5
        step(1'b0, 1'b1, 8'h02, 1'b0);
        clear_counts();
        for (int k = 0; k < 3 * BP + 5; k++) step(1'b0, 1'b0, 8'h02, k >= BP + C);
        check("held_niceplay_count", 32'(nice_cnt), 32'd1);
        check("held_miss_count", 32'(miss_cnt), 32'd0);
        step(1'b1, 1'b0, 8'h02, 1'b1);
        check("rst_midrun_running", 32'(bif.running), 32'd0);
        check("rst_midrun_beat_idx", 32'(bif.beat_idx), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_running", 32'(bif.running), 32'd0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        check("restart_running", 32'(bif.running), 32'd1);
        check("restart_beat_idx", 32'(bif.beat_idx), 32'd0);
        for (int k = 0; k < RUN_LEN + 2; k++) step(1'b0, 1'b0, 8'h00, 1'b0);

        // Random runs: random pattern, button and stray starts; occasional reset
        for (int r = 0; r < 6; r++) begin
            b = 1'b0;
            step(1'b0, 1'b1, 8'($urandom), 1'b0);
            for (int k = 0; k < RUN_LEN + 6; k++) begin
                if ($urandom_range(0, 3) == 0) b = ~b;
                s = ($urandom_range(0, 15) == 0);
                step((r == 3 && k == 70), s, 8'($urandom), b);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
